prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: N, default 2, program address width; program store depth is 2^N bytes.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: load_req  input  1  host request to start or restart a program download.
REQ-005 Port: in_data  input  8  download byte from host.
REQ-006 Port: in_valid  input  1  host asserts when in_data is valid.
REQ-007 Port: in_ready  output  1  loader accepts a byte in any cycle where in_valid and in_ready are both high.
REQ-008 Port: pc_addr  input  N  core program-counter read address.
REQ-009 Port: instruction  output  8  program byte at pc_addr, for the core instruction decode.
REQ-010 Port: core_rst  output  1  active-low hold-in-reset for the core; high only in RUN.
REQ-011 Port: busy  output  1  high in LOAD or CHECK.
REQ-012 Port: error  output  1  high in ERROR.

Function
REQ-013 The block SHALL implement a registered FSM with states IDLE, LOAD, CHECK, RUN and ERROR.
REQ-014 The block SHALL contain a 2^N x 8 program store, a write pointer wr_ptr[N-1:0] and an 8-bit running sum.
REQ-015 In IDLE, load_req=1 SHALL move to LOAD and clear wr_ptr and sum.
REQ-016 In LOAD, each accepted byte SHALL write mem[wr_ptr]=in_data, set sum=(sum+in_data) mod 256 and increment wr_ptr.
REQ-017 An accept at wr_ptr=2^N-1 SHALL move to CHECK; wr_ptr wraps to 0 and the wrap is not an error.
REQ-018 In CHECK, the next accepted byte is the checksum. If it equals sum, the FSM SHALL move to RUN; otherwise it SHALL move to ERROR. The byte is not stored.
REQ-019 in_ready SHALL be combinational: high in LOAD or CHECK and load_req=0; low otherwise.
REQ-020 load_req=1 in LOAD or CHECK SHALL restart the download: stay in or return to LOAD, clear wr_ptr and sum, and accept no byte that cycle.
REQ-021 load_req=1 in RUN or ERROR SHALL move to LOAD, clear wr_ptr and sum, and leave the store contents untouched until new bytes are written.
REQ-022 Outputs SHALL decode from the state register: core_rst=(state==RUN), busy=(LOAD|CHECK), error=(ERROR); each changes one cycle after the causing edge.
REQ-023 In RUN, instruction SHALL be mem[pc_addr] combinationally, with zero-cycle read latency. In every other state it SHALL be 8'h00.
REQ-024 No state other than LOAD SHALL write the store.
REQ-025 in_valid=0 gaps of any length SHALL stall the download with no state change.
REQ-026 In IDLE, RUN and ERROR with load_req=0, in_valid SHALL be ignored.

Reset
REQ-027 rst=0 SHALL asynchronously force: state IDLE, wr_ptr=0, sum=0, every store entry 8'h00, core_rst=0, busy=0, error=0, in_ready=0 and instruction=8'h00.
REQ-028 Deassertion of rst SHALL take effect at the next clock edge with the FSM in IDLE.
REQ-029 Reset asserted mid-download SHALL discard the partial program; a fresh load_req is required.

Verification (N=2)
REQ-030 Normal load: load_req pulse; bytes 11,22,33,44 then checksum AA -> RUN, core_rst=1; pc_addr=2 gives instruction=33; pc_addr=3 gives 44.
REQ-031 Bad checksum: same bytes with checksum AB -> ERROR, error=1, core_rst=0, instruction=00; a new load_req then clean load -> RUN.
REQ-032 Sum wrap: bytes FF,FF,FF,FF with checksum FC -> RUN; checksum 00 -> ERROR.
REQ-033 Backpressure: in_valid toggled 1,0,0,1,... across the load -> same stored contents and RUN as REQ-030; no byte is accepted twice.
REQ-034 Restart and reload: load_req asserted after 2 bytes -> wr_ptr=0 and in_ready=0 that cycle; a full reload from RUN drops core_rst the next cycle and the new program reads back correctly.
REQ-035 Reset mid-load: rst=0 after 3 bytes -> all outputs at reset values immediately; after release, state is IDLE and all entries read 00 once a subsequent valid load reaches RUN with zero bytes.

Source files
------------

// File: rtl/prog_loader_if.sv
// prog_loader_if -- host download / core fetch bundle for prog_loader.
//   load_req    : host request to start or restart a program download
//   in_data     : download byte from the host
//   in_valid    : in_data is valid
//   in_ready    : loader accepts a byte when in_valid && in_ready
//   pc_addr     : core program-counter read address (N bits)
//   instruction : program byte at pc_addr (8'h00 unless running)
//   core_rst    : active-low hold-in-reset for the core, high only when running
//   busy        : download or checksum phase in progress
//   error       : last download failed its checksum
// master = host/core side, slave = loader side.
interface prog_loader_if #(
  parameter int N = 2
);
  logic         load_req;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] pc_addr;
  logic [7:0]   instruction;
  logic         core_rst;
  logic         busy;
  logic         error;

  modport master (
    output load_req, in_data, in_valid, pc_addr,
    input  in_ready, instruction, core_rst, busy, error
  );

  modport slave (
    input  load_req, in_data, in_valid, pc_addr,
    output in_ready, instruction, core_rst, busy, error
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader -- downloads a 2^N-byte program from a host, verifies it with
// an 8-bit additive checksum and then releases the core from reset while
// serving instruction bytes from the program store.
//   clk : single clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : prog_loader_if.slave (download handshake, fetch port, status)
// Download framing: 2^N data bytes followed by one checksum byte equal to
// the sum of the data bytes modulo 256.
module prog_loader #(
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           rst,
  prog_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int DEPTH = 1 << N;

  state_t       state_reg, state_next;
  logic [N-1:0] wr_ptr_reg;
  logic [7:0]   sum_reg;
  logic [7:0]   mem [DEPTH];

  logic in_ready_int;
  logic accept;
  logic wr_en;
  logic last_byte;

  // A pending load_req blocks acceptance so a restart never consumes a byte.
  assign in_ready_int = ((state_reg == LOAD) || (state_reg == CHECK)) && !bus.load_req;
  assign accept       = bus.in_valid && in_ready_int;
  assign wr_en        = accept && (state_reg == LOAD);
  assign last_byte    = (wr_ptr_reg == {N{1'b1}});

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (bus.load_req) begin
      state_next = LOAD;
    end else begin
      case (state_reg)
        LOAD:    if (accept && last_byte) state_next = CHECK;
        CHECK:   if (accept) state_next = (bus.in_data == sum_reg) ? RUN : ERROR;
        default: state_next = state_reg;
      endcase
    end
  end

  // Output decode from the state register
  always_comb begin
    bus.in_ready    = in_ready_int;
    bus.core_rst    = (state_reg == RUN);
    bus.busy        = (state_reg == LOAD) || (state_reg == CHECK);
    bus.error       = (state_reg == ERROR);
    bus.instruction = 8'h00;
    if (state_reg == RUN) begin
      bus.instruction = mem[bus.pc_addr];
    end
  end

  // Write pointer and running sum; load_req clears both from any state.
  // The pointer wraps to 0 after the last data byte, ready for the next load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      sum_reg    <= 8'h00;
    end else if (bus.load_req) begin
      wr_ptr_reg <= '0;
      sum_reg    <= 8'h00;
    end else if (wr_en) begin
      wr_ptr_reg <= wr_ptr_reg + N'(1);
      sum_reg    <= sum_reg + bus.in_data;
    end
  end

  // Program store: one register per entry so reset can clear every byte.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          mem[gi] <= 8'h00;
        end else if (wr_en && (wr_ptr_reg == N'(gi))) begin
          mem[gi] <= bus.in_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int N     = 2;
  localparam int DEPTH = 1 << N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  prog_loader_if #(.N(N)) bus ();

  prog_loader #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // ---------------- behavioural model ----------------
  // The download is a byte list since the last load_req; once it holds
  // DEPTH+1 bytes the outcome is decided from the plain arithmetic sum.
  bit             active = 1'b0;
  bit             ran    = 1'b0;
  bit             failed = 1'b0;
  byte unsigned   rx[$];
  byte unsigned   prog[DEPTH];
  int             s;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      active = 1'b0;
      ran    = 1'b0;
      failed = 1'b0;
      rx.delete();
      for (int i = 0; i < DEPTH; i++) prog[i] = 8'h00;
    end else if (bus.load_req) begin
      active = 1'b1;
      ran    = 1'b0;
      failed = 1'b0;
      rx.delete();
    end else if (active && bus.in_valid) begin
      if (rx.size() < DEPTH) prog[rx.size()] = bus.in_data;
      rx.push_back(bus.in_data);
      if (rx.size() == DEPTH + 1) begin
        s = 0;
        for (int i = 0; i < DEPTH; i++) s += int'(rx[i]);
        active = 1'b0;
        ran    = ((s % 256) == int'(rx[DEPTH]));
        failed = !ran;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    chk("in_ready",    {7'd0, bus.in_ready}, {7'd0, active && !bus.load_req});
    chk("busy",        {7'd0, bus.busy},     {7'd0, active});
    chk("error",       {7'd0, bus.error},    {7'd0, failed});
    chk("core_rst",    {7'd0, bus.core_rst}, {7'd0, ran});
    chk("instruction", bus.instruction,      ran ? prog[bus.pc_addr] : 8'h00);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.in_data = 8'hEE;   // junk while invalid must be ignored
      tick();
    end
  endtask

  task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] ck, input int gap);
    pulse_load();
    send_byte(b0, gap);
    send_byte(b1, gap);
    send_byte(b2, gap);
    send_byte(b3, gap);
    send_byte(ck, gap);
    $display("load %h %h %h %h ck %h gap %0d -> core_rst=%b error=%b",
             b0, b1, b2, b3, ck, gap, bus.core_rst, bus.error);
  endtask

  task automatic read_at(input logic [N-1:0] a, input logic [7:0] exp, input string name);
    bus.pc_addr = a;
    #1;
    chk(name, bus.instruction, exp);
  endtask

  initial begin
    bus.load_req = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.pc_addr  = '0;
    #1 rst = 1'b0;
    #2;
    chk("reset_core_rst", {7'd0, bus.core_rst}, 8'd0);
    chk("reset_busy",     {7'd0, bus.busy},     8'd0);
    chk("reset_in_ready", {7'd0, bus.in_ready}, 8'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Normal load
    load_prog(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 0);
    chk("normal_core_rst", {7'd0, bus.core_rst}, 8'd1);
    read_at(2'd2, 8'h33, "normal_pc2");
    read_at(2'd3, 8'h44, "normal_pc3");

    // Bad checksum, then a clean reload
    load_prog(8'h11, 8'h22, 8'h33, 8'h44, 8'hAB, 0);
    chk("bad_error",    {7'd0, bus.error},    8'd1);
    chk("bad_core_rst", {7'd0, bus.core_rst}, 8'd0);
    read_at(2'd1, 8'h00, "bad_instr");
    load_prog(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 0);
    chk("reload_core_rst", {7'd0, bus.core_rst}, 8'd1);

    // Sum wraps modulo 256
    load_prog(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 0);
    chk("wrap_ok", {7'd0, bus.core_rst}, 8'd1);
    load_prog(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0);
    chk("wrap_bad", {7'd0, bus.error}, 8'd1);

    // Backpressure: valid 1,0,0,1,0,0,...
    load_prog(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 2);
    chk("bp_core_rst", {7'd0, bus.core_rst}, 8'd1);
    read_at(2'd0, 8'h11, "bp_pc0");
    read_at(2'd1, 8'h22, "bp_pc1");
    read_at(2'd2, 8'h33, "bp_pc2");
    read_at(2'd3, 8'h44, "bp_pc3");

    // Restart after two bytes; the byte offered with load_req is refused
    pulse_load();
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    bus.load_req = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    #1;
    chk("restart_in_ready", {7'd0, bus.in_ready}, 8'd0);
    tick();
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_byte(8'h0A, 0);
    $display("restart load 01 02 03 04 ck 0a -> core_rst=%b", bus.core_rst);
    chk("restart_core_rst", {7'd0, bus.core_rst}, 8'd1);
    read_at(2'd0, 8'h01, "restart_pc0");

    // Reload from RUN drops core_rst on the next cycle
    pulse_load();
    chk("reload_drop", {7'd0, bus.core_rst}, 8'd0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h30, 0);
    send_byte(8'h40, 0);
    send_byte(8'hA0, 0);
    $display("reload 10 20 30 40 ck a0 -> core_rst=%b", bus.core_rst);
    read_at(2'd2, 8'h30, "reload_pc2");

    // Reset in the middle of a download
    pulse_load();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    rst = 1'b0;
    #1;
    chk("midrst_busy",     {7'd0, bus.busy},     8'd0);
    chk("midrst_in_ready", {7'd0, bus.in_ready}, 8'd0);
    chk("midrst_instr",    bus.instruction,      8'h00);
    tick();
    rst = 1'b1;
    repeat (3) tick();   // in_valid held high in IDLE is ignored
    chk("post_rst_busy", {7'd0, bus.busy}, 8'd0);
    bus.in_valid = 1'b0;
    load_prog(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    chk("zero_core_rst", {7'd0, bus.core_rst}, 8'd1);
    for (int a = 0; a < DEPTH; a++) read_at(a[N-1:0], 8'h00, "zero_readback");

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
